bus_receiver: RTL and testbench
===============================

BUS_RECEIVER -- requirements
Module: bus_receiver

Interface
REQ-001 The block SHALL have parameter BUS_SIZE, default 16, meaning total input bus width in bits.
REQ-002 The block SHALL have parameter WORD_SIZE, default 4, meaning bits per word; BUS_SIZE is an integer multiple of WORD_SIZE.
REQ-003 The block SHALL have parameter WORD_NUM, default BUS_SIZE/WORD_SIZE, meaning words per bus.
REQ-004 The block SHALL have parameter IDX_W, default 2, meaning word_idx width, with 2**IDX_W >= WORD_NUM.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port data_in, input, BUS_SIZE bits: word-reversed bus, where original word k sits in slice WORD_NUM-1-k.
REQ-008 The block SHALL have port control_in, input, WORD_NUM bits: bit k is 1 when original word k is nonzero.
REQ-009 The block SHALL have port valid_in, input, 1 bit: data_in/control_in are valid.
REQ-010 The block SHALL have port ready_out, output, 1 bit: the block accepts a bus this cycle.
REQ-011 The block SHALL have port word_out, output, WORD_SIZE bits: the emitted word, restored to original order.
REQ-012 The block SHALL have port word_idx, output, IDX_W bits: the original index k of word_out.
REQ-013 The block SHALL have port valid_out, output, 1 bit: word_out/word_idx are valid.
REQ-014 The block SHALL have port ready_in, input, 1 bit: downstream accepts word_out.
REQ-015 The block SHALL have port done_out, output, 1 bit: one-cycle pulse at the end of each accepted bus.
REQ-016 The block SHALL have port error_out, output, 1 bit: sticky flag for a control/data mismatch.

Function
REQ-017 The FSM SHALL have two states: IDLE and SEND; all outputs SHALL be registered or decoded from state only.
REQ-018 In IDLE, ready_out SHALL be 1 and valid_out 0; in SEND, ready_out SHALL be 0 (no skid buffer).
REQ-019 An accept SHALL occur on an edge with IDLE, valid_in=1; the block SHALL capture the un-reversed words into a buffer and control_in into a pending mask.
REQ-020 On an accept with control_in nonzero, the FSM SHALL enter SEND, and valid_out SHALL be 1 in the following cycle (1-cycle latency).
REQ-021 On an accept with control_in all zero, the FSM SHALL stay in IDLE, SHALL emit no word, and done_out SHALL pulse in the following cycle.
REQ-022 In SEND, word_idx SHALL equal the lowest set bit of the pending mask, and word_out SHALL equal buffer word[word_idx].
REQ-023 word_out, word_idx and valid_out SHALL hold stable while valid_out=1 and ready_in=0.
REQ-024 A word handshake (valid_out & ready_in) SHALL clear the corresponding mask bit; the next set bit SHALL be presented in the next cycle, giving one word per cycle under continuous ready_in.
REQ-025 On the handshake that clears the final mask bit, the FSM SHALL return to IDLE, and done_out SHALL be 1 for exactly the following cycle.
REQ-026 Word emission order SHALL be ascending original index; words whose control_in bit is 0 SHALL never be emitted, even if nonzero.
REQ-027 On accept, if any word k has control_in[k] differing from the OR-reduction of word k, error_out SHALL be set in the next cycle and SHALL hold until reset.
REQ-028 valid_in while in SEND SHALL be ignored and SHALL NOT alter the buffer or the mask.

Reset
REQ-029 When reset=1 at an edge, the block SHALL enter IDLE, with valid_out=0, done_out=0, error_out=0, word_out=0, word_idx=0, mask=0 and buffer=0; ready_out SHALL be 1 from the next cycle.
REQ-030 Reset SHALL take priority over any simultaneous accept or handshake; a reset during SEND SHALL discard remaining words, with no done_out pulse.

Verification
REQ-031 data_in=0x4321, control_in=4'b1111, ready_in=1 -> (idx,word) = (0,4),(1,3),(2,2),(3,1) on 4 consecutive cycles; done_out pulses once; error_out stays 0.
REQ-032 data_in=0x00A0, control_in=4'b0100 -> a single word: idx 2, word 0xA; done_out follows 1 cycle later.
REQ-033 data_in=0x0000, control_in=0 -> valid_out stays 0; done_out pulses 1 cycle after accept; ready_out stays 1.
REQ-034 As in REQ-031, with ready_in=0 for 3 cycles on idx 1 -> word 3/idx 1 is held; no word is lost or duplicated; valid_in is ignored during SEND.
REQ-035 data_in=0x4321, control_in=4'b0111 -> words 4,3,2 are emitted (idx 0-2) and idx 3 is never emitted; error_out=1 until reset.
REQ-036 reset asserted for 1 cycle while idx 1 is pending -> next cycle valid_out=0, ready_out=1, error_out=0, no done_out; a new bus is then processed normally.

Source files
------------

// File: rtl/bus_receiver.sv
// bus_receiver: accepts a word-reversed bus, restores original word order and
// emits the words flagged in control_in one at a time, lowest index first.
module bus_receiver #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int WORD_NUM  = BUS_SIZE / WORD_SIZE,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  data_in,
    input  logic [WORD_NUM-1:0]  control_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WORD_SIZE-1:0] word_out,
    output logic [IDX_W-1:0]     word_idx,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 done_out,
    output logic                 error_out
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [WORD_SIZE-1:0] buffer   [WORD_NUM];
    logic [WORD_SIZE-1:0] buffer_n [WORD_NUM];
    logic [WORD_SIZE-1:0] unrev    [WORD_NUM];
    logic [WORD_NUM-1:0]  mask, mask_n;
    logic [WORD_SIZE-1:0] word_n;
    logic [IDX_W-1:0]     idx_n;
    logic                 done_n;
    logic                 error_n;
    logic                 mismatch;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [WORD_NUM-1:0] m);
        lowest_set = '0;
        for (int unsigned i = WORD_NUM; i > 0; i--) begin
            if (m[i-1]) lowest_set = IDX_W'(i - 1);
        end
    endfunction

    assign ready_out = (state == IDLE);
    assign valid_out = (state == SEND);

    // Undo the word reversal and flag any control bit that disagrees with its word.
    always_comb begin
        mismatch = 1'b0;
        for (int unsigned k = 0; k < WORD_NUM; k++) begin
            unrev[k] = data_in[(WORD_NUM - 1 - k) * WORD_SIZE +: WORD_SIZE];
            if (control_in[k] != (|unrev[k])) mismatch = 1'b1;
        end
    end

    // Next-state and next-output decode; the presented word is precomputed so
    // word_out/word_idx leave straight from registers.
    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        mask_n   = mask;
        word_n   = word_out;
        idx_n    = word_idx;
        done_n   = 1'b0;
        error_n  = error_out;
        unique case (state)
            IDLE: begin
                if (valid_in) begin
                    buffer_n = unrev;
                    mask_n   = control_in;
                    if (mismatch) error_n = 1'b1;
                    if (|control_in) begin
                        state_n = SEND;
                        idx_n   = lowest_set(control_in);
                        word_n  = unrev[idx_n];
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SEND: begin
                if (ready_in) begin
                    mask_n = mask & ~(WORD_NUM'(1) << word_idx);
                    if (|mask_n) begin
                        idx_n  = lowest_set(mask_n);
                        word_n = buffer[idx_n];
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            word_out  <= '0;
            word_idx  <= '0;
            done_out  <= 1'b0;
            error_out <= 1'b0;
            for (int unsigned k = 0; k < WORD_NUM; k++) buffer[k] <= '0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            word_out  <= word_n;
            word_idx  <= idx_n;
            done_out  <= done_n;
            error_out <= error_n;
            for (int unsigned k = 0; k < WORD_NUM; k++) buffer[k] <= buffer_n[k];
        end
    end

endmodule

// File: tb/tb_bus_receiver.sv
// Scoreboard bench for bus_receiver: stimulus pushes expected words/done events,
// a negedge monitor pops and compares them.
module tb_bus_receiver;

    localparam int WS = 4;
    localparam int WN = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   data_in = '0;
    logic [3:0]    control_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [3:0]    word_out;
    logic [1:0]    word_idx;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic          done_out;
    logic          error_out;

    bus_receiver #(.BUS_SIZE(16), .WORD_SIZE(4), .WORD_NUM(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .control_in(control_in),
        .valid_in(valid_in), .ready_out(ready_out), .word_out(word_out),
        .word_idx(word_idx), .valid_out(valid_out), .ready_in(ready_in),
        .done_out(done_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct { int bus; int unsigned idx; logic [3:0] word; } wexp_t;
    typedef struct { int bus; logic err; } dexp_t;

    wexp_t wq[$];
    dexp_t dq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    bus_id = 0;
    logic  exp_err = 1'b0;
    bit    rand_mode = 1'b0;
    bit    ready_force = 1'b1;
    wexp_t mon_w;
    dexp_t mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: split the bus by original index and list flagged words in order.
    task automatic model_push(input logic [15:0] d, input logic [3:0] c);
        logic [3:0] w;
        bus_id++;
        for (int k = 0; k < WN; k++) begin
            w = 4'((d >> ((WN - 1 - k) * WS)) & 16'hF);
            if (c[k]) wq.push_back('{bus_id, k, w});
            if (c[k] != (w != 4'h0)) exp_err = 1'b1;
        end
        dq.push_back('{bus_id, exp_err});
    endtask

    // ready_in driver: random backpressure or a level chosen by the main process.
    always @(posedge clk) begin
        #1;
        ready_in = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: compares every handshaken word and every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_vs_valid", 32'(ready_out), 32'(!valid_out));
            if (valid_out && ready_in) begin
                if (wq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_word: got idx %0d word %0h, required none", word_idx, word_out);
                end else begin
                    mon_w = wq.pop_front();
                    check("word_idx", 32'(word_idx), 32'(mon_w.idx));
                    check("word_out", 32'(word_out), 32'(mon_w.word));
                end
            end
            if (done_out) begin
                if (dq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_done: got done_out 1, required 0 at %0t", $time);
                end else begin
                    mon_d = dq.pop_front();
                    check("error_at_done", 32'(error_out), 32'(mon_d.err));
                    check("done_after_words", 32'(wq.size() > 0 && wq[0].bus <= mon_d.bus), 32'(0));
                end
            end
        end
    end

    // Offer a bus; while the DUT is busy, optionally drive ignored junk with valid_in=1.
    task automatic send_bus(input logic [15:0] d, input logic [3:0] c, input bit junk);
        int unsigned n = 0;
        forever begin
            @(negedge clk);
            if (ready_out) begin
                data_in = d; control_in = c; valid_in = 1'b1;
                model_push(d, c);
                break;
            end
            valid_in = junk;
            data_in = 16'($urandom);
            control_in = 4'($urandom);
            n++;
            if (n > 400) begin
                check("accept_timeout", 32'(1), 32'(0));
                break;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        forever begin
            @(negedge clk);
            if (wq.size() == 0 && dq.size() == 0 && ready_out) break;
            n++;
            if (n > 1000) begin
                check("drain_timeout", 32'(wq.size() + dq.size()), 32'(0));
                wq.delete(); dq.delete();
                break;
            end
        end
    endtask

    task automatic wait_valid();
        int unsigned n = 0;
        while (!valid_out) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("valid_timeout", 32'(valid_out), 32'(1));
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; valid_in = 1'b0;
        wq.delete(); dq.delete(); exp_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  c;
        logic [3:0]  w;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready_out", 32'(ready_out), 32'(1));
        check("rst_valid_out", 32'(valid_out), 32'(0));
        check("rst_done_out", 32'(done_out), 32'(0));
        check("rst_error_out", 32'(error_out), 32'(0));
        check("rst_word_out", 32'(word_out), 32'(0));
        check("rst_word_idx", 32'(word_idx), 32'(0));

        // Full bus, single word, empty bus.
        send_bus(16'h4321, 4'b1111, 1'b0); wait_drain();
        send_bus(16'h00A0, 4'b0100, 1'b0); wait_drain();
        send_bus(16'h0000, 4'b0000, 1'b0);
        @(negedge clk);
        check("empty_ready_out", 32'(ready_out), 32'(1));
        wait_drain();

        // Backpressure on idx 1 for three cycles with junk offered meanwhile.
        ready_force = 1'b0;
        send_bus(16'h4321, 4'b1111, 1'b0);
        @(negedge clk);
        wait_valid();
        ready_force = 1'b1;
        valid_in = 1'b1; data_in = 16'hFFFF; control_in = 4'b1111;
        @(negedge clk);
        ready_force = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(valid_out), 32'(1));
            check("stall_idx", 32'(word_idx), 32'(1));
            check("stall_word", 32'(word_out), 32'(3));
        end
        ready_force = 1'b1;
        valid_in = 1'b0;
        wait_drain();

        // Unflagged nonzero word: never emitted, sticky error.
        send_bus(16'h4321, 4'b0111, 1'b0); wait_drain();
        repeat (2) @(negedge clk);
        check("error_sticky", 32'(error_out), 32'(1));

        // Reset while idx 1 is pending.
        ready_force = 1'b0;
        send_bus(16'h4321, 4'b1111, 1'b0);
        @(negedge clk);
        wait_valid();
        ready_force = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        wq.delete(); dq.delete(); exp_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_send_valid", 32'(valid_out), 32'(0));
        check("rst_send_ready", 32'(ready_out), 32'(1));
        check("rst_send_error", 32'(error_out), 32'(0));
        check("rst_send_done", 32'(done_out), 32'(0));
        ready_force = 1'b1;
        send_bus(16'h00A0, 4'b0100, 1'b0); wait_drain();

        // Randomized rounds, each starting from reset.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rand_mode = 1'b1;
            for (int b = 0; b < 40; b++) begin
                d = '0; c = '0;
                for (int k = 0; k < WN; k++) begin
                    w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    d[(WN - 1 - k) * WS +: WS] = w;
                    c[k] = (w != 4'h0);
                end
                if ($urandom_range(0, 15) == 0) c[$urandom_range(0, 3)] ^= 1'b1;
                send_bus(d, c, 1'($urandom_range(0, 1)));
            end
            wait_drain();
            rand_mode = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
